av_console_tx: RTL and testbench

//  Avalon-MM slave console at the core's debug-output window (0x1000000) on the data bus.

---
 rtl/av_console_tx.sv | 170 +++++++++++++++++
 tb/tb_av_console_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/av_console_tx.sv
// Avalon-MM console: byte writes are queued in a FIFO and sent on a UART line (8N1, LSB first).
// Waitrequest stalls DATA writes while the FIFO is full. STATUS reports FIFO state and TX activity.
module av_console_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        avs_waitrequest,
   output logic        tx
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

   state_t             state;
   logic [TMR_W-1:0]   timer;
   logic [2:0]         idx;
   logic [7:0]         shift;

   logic [7:0]         mem [DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [CNT_W-1:0]   count;

   logic full;
   logic empty;
   logic busy;
   logic data_wr;
   logic push;
   logic flush;
   logic pop;
   logic bit_done;
   logic [31:0] status;

   // Upper data lanes are ignored by both registers.
   logic unused_bits;
   assign unused_bits = ^{avs_writedata[31:8], avs_byteenable[3:1]};

   // Decode of bus writes, FIFO flags and the FSM pop request.
   always_comb begin
      full            = (count == CNT_W'(DEPTH));
      empty           = (count == '0);
      busy            = (state != StIdle);
      bit_done        = (timer == '0);
      data_wr         = avs_write & ~avs_address & avs_byteenable[0];
      avs_waitrequest = data_wr & full;
      push            = data_wr & ~full;
      flush           = avs_write & avs_address & avs_writedata[0];
      // Flush wins over a pop in the same cycle: the FSM does not start on flushed data.
      pop             = ~flush & ~empty &
                        ((state == StIdle) | ((state == StStop) & bit_done));
      status          = {16'h0, 8'(count), 5'b0, busy, empty, full};
   end

   // FIFO storage; no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= avs_writedata[7:0];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Read port: zero-wait accept, data and valid registered one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= '0;
      end else begin
         avs_readdatavalid <= avs_read;
         if (avs_read) begin
            avs_readdata <= avs_address ? status : 32'h0;
         end
      end
   end

   // UART transmit FSM with registered tx.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= StIdle;
         timer <= '0;
         idx   <= '0;
         shift <= '0;
         tx    <= 1'b1;
      end else begin
         unique case (state)
            StIdle: begin
               if (pop) begin
                  shift <= mem[rptr];
                  tx    <= 1'b0;
                  timer <= TMR_W'(CLKS_PER_BIT - 1);
                  state <= StStart;
               end
            end
            StStart: begin
               if (bit_done) begin
                  tx    <= shift[0];
                  idx   <= '0;
                  timer <= TMR_W'(CLKS_PER_BIT - 1);
                  state <= StData;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            StData: begin
               if (bit_done) begin
                  timer <= TMR_W'(CLKS_PER_BIT - 1);
                  if (idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= StStop;
                  end else begin
                     shift <= shift >> 1;
                     tx    <= shift[1];
                     idx   <= idx + 1'b1;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            StStop: begin
               if (bit_done) begin
                  // Back-to-back frames: next start bit follows the stop bit directly.
                  if (pop) begin
                     shift <= mem[rptr];
                     tx    <= 1'b0;
                     timer <= TMR_W'(CLKS_PER_BIT - 1);
                     state <= StStart;
                  end else begin
                     state <= StIdle;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_av_console_tx.sv
// Bench for av_console_tx: directed scenarios plus random traffic, checked every cycle against
// a frame-level model (byte queue + 10-bit frame timeline).
module tb_av_console_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LAST  = 10 * CPB - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        avs_address;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic        avs_waitrequest;
   logic        tx;

   av_console_tx #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH),
      .CNT_W        (3)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .avs_address       (avs_address),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_byteenable    (avs_byteenable),
      .avs_read          (avs_read),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .avs_waitrequest   (avs_waitrequest),
      .tx                (tx)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0]  q[$];
   bit          active;
   int          pos;
   logic [9:0]  frame;
   logic        exp_rdv;
   logic [31:0] exp_rd;
   bit          last_accept;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      active  = 0;
      pos     = 0;
      frame   = '1;
      exp_rdv = 0;
      exp_rd  = 0;
   endtask

   // One clock: check waitrequest before the edge, advance the model, check outputs after it.
   task automatic cycle();
      logic m_full, m_empty, exp_wr, push, flush, pop;
      @(negedge clk);
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      exp_wr  = avs_write && !avs_address && avs_byteenable[0] && m_full;
      check("waitrequest", {31'h0, avs_waitrequest}, {31'h0, exp_wr});
      push  = avs_write && !avs_address && avs_byteenable[0] && !m_full;
      flush = avs_write && avs_address && avs_writedata[0];
      pop   = (!active || pos == LAST) && !m_empty && !flush;
      if (avs_read)
         exp_rd = avs_address ? {16'h0, 8'(q.size()), 5'b0, active, m_empty, m_full} : 32'h0;
      exp_rdv = avs_read;
      if (pop) begin
         frame  = {1'b1, q[0], 1'b0};
         active = 1;
         pos    = 0;
      end else if (active) begin
         if (pos == LAST) active = 0;
         else pos++;
      end
      if (flush) q.delete();
      else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(avs_writedata[7:0]);
      end
      last_accept = avs_write && !exp_wr;
      @(posedge clk);
      #1;
      check("tx", {31'h0, tx}, {31'h0, active ? frame[pos / CPB] : 1'b1});
      check("readdatavalid", {31'h0, avs_readdatavalid}, {31'h0, exp_rdv});
      check("readdata", avs_readdata, exp_rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wr(input logic addr, input logic [31:0] d, input logic [3:0] be);
      avs_write      = 1;
      avs_address    = addr;
      avs_writedata  = d;
      avs_byteenable = be;
      last_accept    = 0;
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (last_accept) break;
      end
      n_assert++;
      assert (last_accept) else begin
         n_fail++;
         $error("FAIL write_timeout: observed stalled expected accepted");
      end
      avs_write = 0;
   endtask

   task automatic rd(input logic addr, output logic [31:0] data);
      avs_read    = 1;
      avs_address = addr;
      cycle();
      data     = avs_readdata;
      avs_read = 0;
   endtask

   initial begin
      logic [31:0] r;
      int          guard;
      reset          = 1;
      avs_address    = 0;
      avs_write      = 0;
      avs_writedata  = 0;
      avs_byteenable = 0;
      avs_read       = 0;
      model_reset();
      #1;
      check("rst_tx", {31'h0, tx}, 32'h1);
      check("rst_rdv", {31'h0, avs_readdatavalid}, 32'h0);
      check("rst_rd", avs_readdata, 32'h0);
      check("rst_waitreq", {31'h0, avs_waitrequest}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 0;

      // 1: single byte, tx falls the edge after the write
      wr(0, 32'h41, 4'hf);
      cycle();
      check("t1_tx_fall", {31'h0, tx}, 32'h0);
      idle(45);
      rd(1, r);
      check("t1_status", r, 32'h002);

      // 2: six back-to-back writes, last one stalls on a full FIFO
      for (int b = 1; b <= 6; b++) wr(0, b, 4'hf);
      idle(6 * 40 + 10);

      // 3: status while busy with 3 queued, then DATA read
      for (int b = 0; b < 4; b++) wr(0, 32'h70 + b, 4'hf);
      rd(1, r);
      check("t3_status", r, 32'h304);
      rd(0, r);
      check("t3_data", r, 32'h0);
      idle(4 * 40 + 10);

      // 4: flush mid-frame
      for (int b = 0; b < 5; b++) wr(0, 32'hA0 + b, 4'hf);
      idle(10);
      wr(1, 32'h1, 4'hf);
      rd(1, r);
      check("t4_status_busy", r, 32'h006);
      idle(50);
      rd(1, r);
      check("t4_status", r, 32'h002);

      // 5: reset during data bit 3
      wr(0, 32'h3C, 4'hf);
      guard = 0;
      while (!(active && pos == 17) && guard < 60) begin
         cycle();
         guard++;
      end
      #2 reset = 1;
      #1;
      check("t5_tx_async", {31'h0, tx}, 32'h1);
      model_reset();
      @(posedge clk);
      #1 reset = 0;
      rd(1, r);
      check("t5_status", r, 32'h002);
      wr(0, 32'h55, 4'hf);
      idle(45);

      // 6: byte lane 0 disabled, no push
      wr(0, 32'hAA, 4'b1110);
      idle(10);
      rd(1, r);
      check("t6_status", r, 32'h002);

      // Random traffic
      for (int i = 0; i < 80; i++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 5)
            wr(0, $urandom, ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hf);
         else if (op == 6) begin
            rd(1'($urandom), r);
         end else if (op == 7)
            wr(1, {$urandom_range(0, 255), 23'h0, ($urandom_range(0, 3) == 0)}, 4'hf);
         else if (op == 8)
            idle($urandom_range(1, 10));
         else
            idle($urandom_range(20, 60));
      end
      idle(DEPTH * 40 + 50);
      rd(1, r);
      check("final_status", r, 32'h002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
